// File: rtl/riscv_test_monitor_pkg.sv
// Shared definitions for the riscv-tests end-of-test monitor:
// FSM state encodings, the pass test number and the default end-loop PC.
package riscv_test_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  // gp value that riscv-tests leaves behind on success
  localparam logic [31:0] TESTNUM_PASS   = 32'd1;

  // PC of the ecall/end loop in the standard riscv-tests link map
  localparam logic [31:0] DEFAULT_END_PC = 32'h0000_0044;

endpackage

// File: rtl/riscv_test_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module riscv_test_monitor_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE     = W'(1'b1);
  localparam logic [W-1:0] ALL_ONE = {W{1'b1}};

  // count register: reset/clear to zero, increment until all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (inc && (q != ALL_ONE)) begin
      q <= q + ONE;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/riscv_test_monitor.sv
// End-of-test detector for riscv-tests runs. Watches pc/gp for the end loop,
// optionally a tohost store, and reports pass / fail(testnum) / timeout.
// Optional feature: define RISCV_TEST_MONITOR_TOHOST_EN to let tohost writes
// end the test; otherwise the tohost_* ports are present but ignored.
module riscv_test_monitor
  import riscv_test_monitor_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] END_PC         = XLEN'(DEFAULT_END_PC),
  parameter int              STABLE_CYCLES  = 2,
  parameter int              TIMEOUT_CYCLES = 5000,
  parameter int              CNT_W          = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = XLEN'(32'h0000_1000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pc_valid,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   gp,
  input  logic              tohost_we,
  input  logic [XLEN-1:0]   tohost_addr,
  input  logic [XLEN-1:0]   tohost_wdata,
  output logic              done,
  output logic              done_pulse,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [XLEN-2:0]   fail_testnum,
  output logic [CNT_W-1:0]  cycle_count
);

  // wide enough to hold STABLE_CYCLES
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  state_e            state_r;
  state_e            state_next_s;
  logic [XLEN-2:0]   testnum_next_s;
  logic [SW-1:0]     stable_cnt_s;
  logic              in_run_s;
  logic              end_hit_s;
  logic              pc_verdict_s;
  logic              timeout_hit_s;
  logic              tohost_hit_s;

  assign in_run_s      = (state_r == ST_RUN);
  assign end_hit_s     = pc_valid && (pc == END_PC);
  // this cycle is the STABLE_CYCLES-th consecutive dwell at END_PC
  assign pc_verdict_s  = in_run_s && end_hit_s &&
                         (stable_cnt_s == SW'(STABLE_CYCLES - 1));
  assign timeout_hit_s = in_run_s && (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef RISCV_TEST_MONITOR_TOHOST_EN
  // tohost stores with bit 0 set terminate the test
  assign tohost_hit_s = in_run_s && tohost_we &&
                        (tohost_addr == TOHOST_ADDR) && tohost_wdata[0];
`else
  logic unused_tohost_s;
  assign unused_tohost_s = ^{tohost_we, tohost_addr, tohost_wdata};
  assign tohost_hit_s    = 1'b0;
`endif

  riscv_test_monitor_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .inc   (in_run_s),
    .q     (cycle_count)
  );

  riscv_test_monitor_sat_counter #(.W(SW)) u_stable_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (!(in_run_s && end_hit_s)),
    .inc   (in_run_s && end_hit_s),
    .q     (stable_cnt_s)
  );

  // next state and verdict test number; tohost > PC > timeout
  always_comb begin
    state_next_s   = state_r;
    testnum_next_s = '0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (tohost_hit_s) begin
          if (tohost_wdata == XLEN'(TESTNUM_PASS)) begin
            state_next_s = ST_PASS;
          end else begin
            state_next_s   = ST_FAIL;
            testnum_next_s = tohost_wdata[XLEN-1:1];
          end
        end else if (pc_verdict_s) begin
          if (gp == XLEN'(TESTNUM_PASS)) begin
            state_next_s = ST_PASS;
          end else begin
            state_next_s   = ST_FAIL;
            testnum_next_s = gp[XLEN-1:1];
          end
        end else if (timeout_hit_s) begin
          state_next_s = ST_TIMEOUT;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_PASS:    state_next_s = ST_PASS;
      ST_FAIL:    state_next_s = ST_FAIL;
      ST_TIMEOUT: state_next_s = ST_TIMEOUT;
      default:    state_next_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // sticky verdict flags, captured once on leaving RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      done         <= 1'b0;
      done_pulse   <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      fail_testnum <= '0;
    end else if (in_run_s && (state_next_s != ST_RUN)) begin
      done         <= 1'b1;
      done_pulse   <= 1'b1;
      pass         <= (state_next_s == ST_PASS);
      fail         <= (state_next_s == ST_FAIL);
      timeout      <= (state_next_s == ST_TIMEOUT);
      fail_testnum <= testnum_next_s;
    end else begin
      done_pulse   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Scoreboard bench for riscv_test_monitor: a driver issues directed and
// random runs and queues the expected verdict from a reference model;
// a monitor pops and compares whenever done_pulse is seen.
module tb_riscv_test_monitor;

  localparam int          XLEN    = 32;
  localparam logic [31:0] END_PC  = 32'h0000_0044;
  localparam int          STABLE  = 2;
  localparam int          TMO     = 20;
  localparam int          CNT_W   = 32;
  localparam logic [31:0] TOHOST  = 32'h0000_1000;
`ifdef RISCV_TEST_MONITOR_TOHOST_EN
  localparam bit          TOHOST_EN = 1'b1;
`else
  localparam bit          TOHOST_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, start, pc_valid, tohost_we;
  logic [XLEN-1:0]   pc, gp, tohost_addr, tohost_wdata;
  logic              done, done_pulse, pass, fail, timeout;
  logic [XLEN-2:0]   fail_testnum;
  logic [CNT_W-1:0]  cycle_count;

  riscv_test_monitor #(
    .XLEN(XLEN), .END_PC(END_PC), .STABLE_CYCLES(STABLE),
    .TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W), .TOHOST_ADDR(TOHOST)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pc_valid(pc_valid), .pc(pc), .gp(gp),
    .tohost_we(tohost_we), .tohost_addr(tohost_addr), .tohost_wdata(tohost_wdata),
    .done(done), .done_pulse(done_pulse), .pass(pass), .fail(fail),
    .timeout(timeout), .fail_testnum(fail_testnum), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          p;
    bit          f;
    bit          to;
    logic [30:0] tn;
    logic [31:0] cc;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   checks   = 0;
  int   failures = 0;

  // reference model state: cycles spent in RUN and current END_PC streak
  bit   in_run;
  int   t;
  int   streak;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // monitor: invariants every cycle, scoreboard pop on each done_pulse
  always @(negedge clk) begin
    chk("done_is_or", {63'd0, done}, {63'd0, pass | fail | timeout});
    chk("one_verdict", {63'd0, ($countones({pass, fail, timeout}) > 1)}, 64'd0);
    if (done_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_pass",    {63'd0, pass},    {63'd0, e.p});
        chk("sb_fail",    {63'd0, fail},    {63'd0, e.f});
        chk("sb_timeout", {63'd0, timeout}, {63'd0, e.to});
        chk("sb_testnum", {33'd0, fail_testnum}, {33'd0, e.tn});
        chk("sb_cycles",  {32'd0, cycle_count},  {32'd0, e.cc});
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_done"},  {63'd0, done},       64'd0);
    chk({tag, "_pulse"}, {63'd0, done_pulse}, 64'd0);
    chk({tag, "_flags"}, {61'd0, pass, fail, timeout}, 64'd0);
    chk({tag, "_tnum"},  {33'd0, fail_testnum}, 64'd0);
    chk({tag, "_cc"},    {32'd0, cycle_count},  64'd0);
  endtask

  task automatic idle_inputs();
    start = 1'b0; pc_valid = 1'b0; pc = 32'd0; gp = 32'd0;
    tohost_we = 1'b0; tohost_addr = 32'd0; tohost_wdata = 32'd0;
  endtask

  // reset from a negedge; model leaves RUN
  task automatic do_reset(input string tag);
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    in_run = 1'b0;
    check_zero(tag);
  endtask

  task automatic arm();
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    in_run = 1'b1; t = 0; streak = 0;
    chk("arm_cc", {32'd0, cycle_count}, 64'd0);
    chk("arm_done", {63'd0, done}, 64'd0);
  endtask

  // drive one RUN cycle, predict its outcome, advance the clock
  task automatic step(input logic v, input logic [31:0] p, input logic [31:0] g,
                      input logic we, input logic [31:0] a, input logic [31:0] d,
                      output bit ended);
    exp_t e;
    bit   verdict;
    start = 1'($urandom_range(0, 1));
    pc_valid = v; pc = p; gp = g;
    tohost_we = we; tohost_addr = a; tohost_wdata = d;
    ended = 1'b0;
    verdict = 1'b0;
    e = '{p: 1'b0, f: 1'b0, to: 1'b0, tn: 31'd0, cc: 32'd0};
    streak = (v && p == END_PC) ? streak + 1 : 0;
    if (TOHOST_EN && we && a == TOHOST && d[0]) begin
      verdict = 1'b1;
      if (d == 32'd1) e.p = 1'b1; else begin e.f = 1'b1; e.tn = d[31:1]; end
    end else if (streak == STABLE) begin
      verdict = 1'b1;
      if (g == 32'd1) e.p = 1'b1; else begin e.f = 1'b1; e.tn = g[31:1]; end
    end else if (t == TMO - 1) begin
      verdict = 1'b1;
      e.to = 1'b1;
    end
    t++;
    if (verdict) begin
      e.cc = 32'(t);
      exp_q.push_back(e);
      last_exp = e;
      ended = 1'b1;
      in_run = 1'b0;
    end
    @(posedge clk); @(negedge clk);
    if (!ended) begin
      chk("run_cc", {32'd0, cycle_count}, 64'(t));
      chk("run_done", {63'd0, done}, 64'd0);
    end
  endtask

  // wait (bounded) for the monitor to consume the verdict, then check it sticks
  task automatic drain_and_hold(input int n);
    int k = 0;
    while (exp_q.size() != 0 && k < 4) begin
      @(negedge clk); k++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      start = 1'($urandom_range(0, 1));
      pc_valid = 1'b1; pc = END_PC; gp = $urandom;
      tohost_we = 1'b1; tohost_addr = TOHOST; tohost_wdata = 32'd1;
      @(posedge clk); @(negedge clk);
      chk("hold_pulse", {63'd0, done_pulse}, 64'd0);
      chk("hold_flags", {61'd0, pass, fail, timeout},
          {61'd0, last_exp.p, last_exp.f, last_exp.to});
      chk("hold_tnum", {33'd0, fail_testnum}, {33'd0, last_exp.tn});
      chk("hold_cc",   {32'd0, cycle_count},  {32'd0, last_exp.cc});
    end
  endtask

  function automatic logic [31:0] rand_gp();
    case ($urandom_range(0, 3))
      0:       return 32'd1;
      1:       return 32'd0;
      2:       return 32'h0000_000b;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_wdata();
    case ($urandom_range(0, 3))
      0:       return 32'd1;
      1:       return 32'd7;
      2:       return 32'd2;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ended;
    rst = 1'b1;
    idle_inputs();
    in_run = 1'b0; t = 0; streak = 0;
    last_exp = '{p: 1'b0, f: 1'b0, to: 1'b0, tn: 31'd0, cc: 32'd0};
    @(negedge clk);
    do_reset("reset");

    // no start: monitor stays idle whatever the core does
    for (int i = 0; i < 100; i++) begin
      pc_valid = 1'b1; pc = END_PC; gp = 32'd1;
      tohost_we = 1'b1; tohost_addr = TOHOST; tohost_wdata = 32'd1;
      @(posedge clk); @(negedge clk);
      if (i % 25 == 24) check_zero("idle");
    end

    // pass via END_PC dwell with gp=1
    do_reset("rst_pass");
    arm();
    step(1'b1, END_PC, 32'd1, 1'b0, 32'd0, 32'd0, ended);
    step(1'b1, END_PC, 32'd1, 1'b0, 32'd0, 32'd0, ended);
    drain_and_hold(50);

    // fail with gp=0xb -> testnum 5
    do_reset("rst_fail");
    arm();
    step(1'b1, END_PC, 32'h0000_000b, 1'b0, 32'd0, 32'd0, ended);
    step(1'b1, END_PC, 32'h0000_000b, 1'b0, 32'd0, 32'd0, ended);
    drain_and_hold(5);

    // pc never reaches END_PC -> timeout after TMO cycles
    do_reset("rst_tmo");
    arm();
    ended = 1'b0;
    for (int i = 0; i < TMO + 2 && !ended; i++)
      step(1'b1, 32'h0000_0040, 32'd1, 1'b0, 32'd0, 32'd0, ended);
    drain_and_hold(10);

    // broken dwell restarts the streak; then reset mid-dwell
    do_reset("rst_dwell");
    arm();
    step(1'b1, END_PC,         32'd1, 1'b0, 32'd0, 32'd0, ended);
    step(1'b1, 32'h0000_0040,  32'd1, 1'b0, 32'd0, 32'd0, ended);
    step(1'b1, END_PC,         32'd1, 1'b0, 32'd0, 32'd0, ended);
    step(1'b1, END_PC,         32'd1, 1'b0, 32'd0, 32'd0, ended);
    drain_and_hold(3);
    do_reset("rst_dwell2");
    arm();
    step(1'b1, END_PC, 32'd1, 1'b0, 32'd0, 32'd0, ended);
    do_reset("rst_middwell");

    // tohost 0x2 ignored; tohost 0x7 alongside a PC pass wins (if enabled)
    arm();
    step(1'b1, END_PC, 32'd1, 1'b1, TOHOST, 32'd2, ended);
    step(1'b1, END_PC, 32'd1, 1'b1, TOHOST, 32'd7, ended);
    drain_and_hold(3);

    // random runs with occasional mid-run reset
    for (int r = 0; r < 40; r++) begin
      do_reset("rst_rand");
      arm();
      ended = 1'b0;
      for (int c = 0; c < TMO + 2 && !ended; c++) begin
        if ($urandom_range(0, 59) == 0) begin
          do_reset("rand_abort");
          break;
        end
        step(1'($urandom_range(0, 6) != 0),
             ($urandom_range(0, 9) < 6) ? END_PC : (($urandom_range(0, 1) == 1) ? 32'h0000_0040 : $urandom),
             rand_gp(),
             1'($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) < 7) ? TOHOST : $urandom,
             rand_wdata(),
             ended);
      end
      if (ended) drain_and_hold(4);
    end

    do_reset("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
